// File: rtl/bp_lane_ld_ctrl.sv
// Load controller: unpacks an AXI-Stream bus into NUM_LANES per-lane buffer
// write ports, sequencing cfg_words buffer words into one ping-pong bank.
module bp_lane_ld_ctrl #(
  parameter int BUS_DW    = 64,
  parameter int LANE_DW   = 16,
  parameter int NUM_LANES = 15,
  parameter int ADDR_W    = 9,
  parameter int WORDS_W   = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic [WORDS_W-1:0]            cfg_words,
  input  logic [ADDR_W-1:0]             cfg_base_addr,
  input  logic                          cfg_sel,
  output logic                          busy,
  output logic                          done,
  output logic                          err_tlast,
  input  logic [BUS_DW-1:0]             s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [NUM_LANES-1:0]          buf_wr_en,
  output logic                          buf_wr_sel,
  output logic [ADDR_W-1:0]             buf_wr_addr,
  output logic [NUM_LANES*LANE_DW-1:0]  buf_wr_data,
  output logic [1:0]                    dbg_state
);

  localparam int LPB   = BUS_DW / LANE_DW;
  localparam int NGRP  = (NUM_LANES + LPB - 1) / LPB;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                         state_q;
  logic [WORDS_W-1:0]             words_q;
  logic [ADDR_W-1:0]              base_q;
  logic                           sel_q;
  logic [GRP_W-1:0]               grp_cnt_q;
  logic [WORDS_W-1:0]             word_cnt_q;
  logic                           err_q;
  logic [NUM_LANES-1:0]           wr_en_q;
  logic [ADDR_W-1:0]              wr_addr_q;
  logic [NUM_LANES*LANE_DW-1:0]   wr_data_q;

  logic                           hs;
  logic                           last_grp;
  logic                           last_beat;
  logic [NUM_LANES-1:0]           grp_mask;
  logic [NUM_LANES*LANE_DW-1:0]   lane_data;

  // A beat is accepted on tvalid & tready; tready depends on the state register only.
  assign s_axis_tready = (state_q == S_LOAD);
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign last_grp      = (grp_cnt_q == GRP_W'(NGRP - 1));
  assign last_beat     = last_grp && (word_cnt_q == (words_q - WORDS_W'(1)));

  // Lane L belongs to beat group L/LPB and takes slice L mod LPB of the bus.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign grp_mask[l] = (grp_cnt_q == GRP_W'(l / LPB));
    assign lane_data[l*LANE_DW +: LANE_DW] = s_axis_tdata[(l % LPB)*LANE_DW +: LANE_DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      words_q    <= '0;
      base_q     <= '0;
      sel_q      <= 1'b0;
      grp_cnt_q  <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            words_q    <= cfg_words;
            base_q     <= cfg_base_addr;
            sel_q      <= cfg_sel;
            err_q      <= 1'b0;
            grp_cnt_q  <= '0;
            word_cnt_q <= '0;
            state_q    <= (cfg_words == '0) ? S_FIN : S_LOAD;
          end
        end
        S_LOAD: begin
          if (hs) begin
            wr_en_q   <= grp_mask;
            wr_data_q <= lane_data;
            wr_addr_q <= base_q + ADDR_W'(word_cnt_q);
            // tlast is only checked; the beat count alone ends the transfer.
            if (s_axis_tlast != last_beat) err_q <= 1'b1;
            if (last_grp) begin
              grp_cnt_q  <= '0;
              word_cnt_q <= word_cnt_q + WORDS_W'(1);
            end else begin
              grp_cnt_q  <= grp_cnt_q + GRP_W'(1);
            end
            if (last_beat) state_q <= S_FIN;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign err_tlast   = err_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_sel  = sel_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bp_lane_ld_ctrl.sv
// Bench for bp_lane_ld_ctrl: default 16-bit/15-lane instance with a write
// scoreboard, plus an 8-bit/14-lane instance for the generic lane split.
module tb_bp_lane_ld_ctrl;

  localparam int DW    = 15 * 16;
  localparam int EXP_W = 1 + 9 + 15 + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           cfg_start = 1'b0;
  logic [9:0]     cfg_words = '0;
  logic [8:0]     cfg_base_addr = '0;
  logic           cfg_sel = 1'b0;
  logic           busy, done, err_tlast, s_axis_tready, buf_wr_sel;
  logic [63:0]    s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tlast = 1'b0;
  logic [14:0]    buf_wr_en;
  logic [8:0]     buf_wr_addr;
  logic [DW-1:0]  buf_wr_data;
  logic [1:0]     dbg_state;

  bp_lane_ld_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_words(cfg_words),
    .cfg_base_addr(cfg_base_addr), .cfg_sel(cfg_sel), .busy(busy), .done(done),
    .err_tlast(err_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .buf_wr_en(buf_wr_en),
    .buf_wr_sel(buf_wr_sel), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .dbg_state(dbg_state)
  );

  logic           start8 = 1'b0;
  logic [9:0]     words8 = '0;
  logic [8:0]     base8 = '0;
  logic           sel8 = 1'b0;
  logic           busy8, done8, err8, tready8, wsel8;
  logic [63:0]    tdata8 = '0;
  logic           tvalid8 = 1'b0;
  logic           tlast8 = 1'b0;
  logic [13:0]    en8;
  logic [8:0]     addr8;
  logic [111:0]   data8;
  logic [1:0]     dbg8;

  bp_lane_ld_ctrl #(.BUS_DW(64), .LANE_DW(8), .NUM_LANES(14), .ADDR_W(9), .WORDS_W(10)) dut8 (
    .clk(clk), .rst_n(rst_n), .cfg_start(start8), .cfg_words(words8),
    .cfg_base_addr(base8), .cfg_sel(sel8), .busy(busy8), .done(done8),
    .err_tlast(err8), .s_axis_tdata(tdata8), .s_axis_tvalid(tvalid8),
    .s_axis_tready(tready8), .s_axis_tlast(tlast8), .buf_wr_en(en8),
    .buf_wr_sel(wsel8), .buf_wr_addr(addr8), .buf_wr_data(data8),
    .dbg_state(dbg8)
  );

  int checks = 0;
  int passed = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [63:0]      beat_q[$];
  logic [14:0]      masks16 [4] = '{15'h000F, 15'h00F0, 15'h0F00, 15'h7000};

  task automatic run_xfer(input int base, input int words, input bit sel,
                          input bit stall, input int bad_beat);
    int total, beat, cyc;
    bit hs, done_seen, tready_ok;
    logic [63:0] d;
    logic [DW-1:0] ed, m;
    logic [EXP_W-1:0] e;
    total = words * 4;
    beat_q.delete();
    exp_q.delete();
    for (int b = 0; b < total; b++) begin
      d = {$urandom, $urandom};
      beat_q.push_back(d);
      for (int l = 0; l < 15; l++) ed[l*16 +: 16] = d[(l % 4)*16 +: 16];
      exp_q.push_back({sel, 9'((base + b / 4) % 512), masks16[b % 4], ed});
    end
    cfg_base_addr = 9'(base);
    cfg_words = 10'(words);
    cfg_sel = sel;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || err_tlast !== 1'b0)
      $display("FAIL start_state: busy=%b err=%b required busy=1 err=0", busy, err_tlast);
    else passed++;
    beat = 0; cyc = 0; done_seen = 0; tready_ok = 1;
    while (!done_seen && cyc < 400) begin
      if (beat < total && (!stall || (cyc % 2) == 0)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat_q[beat];
        s_axis_tlast  = (bad_beat < 0) ? (beat == total - 1) : (beat == bad_beat);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tlast  = 1'($urandom_range(0, 1));
      end
      if (beat < total && s_axis_tready !== 1'b1) tready_ok = 0;
      hs = s_axis_tvalid && s_axis_tready;
      @(negedge clk);
      cyc++;
      if (hs) beat++;
      if (buf_wr_en !== '0) begin
        checks++;
        if (!hs) $display("FAIL write_no_hs: wr_en=%h without a handshake, required 0000", buf_wr_en);
        else passed++;
        checks++;
        if (exp_q.size() == 0) $display("FAIL extra_write: wr_en=%h with empty scoreboard", buf_wr_en);
        else begin
          passed++;
          e = exp_q.pop_front();
          m = '0;
          for (int l = 0; l < 15; l++) if (e[DW + l]) m[l*16 +: 16] = '1;
          checks++;
          if (buf_wr_en !== e[DW +: 15]) $display("FAIL wr_en: got %h required %h", buf_wr_en, e[DW +: 15]);
          else passed++;
          checks++;
          if (buf_wr_addr !== e[DW+15 +: 9]) $display("FAIL wr_addr: got %h required %h", buf_wr_addr, e[DW+15 +: 9]);
          else passed++;
          checks++;
          if (buf_wr_sel !== e[EXP_W-1]) $display("FAIL wr_sel: got %b required %b", buf_wr_sel, e[EXP_W-1]);
          else passed++;
          checks++;
          if ((buf_wr_data & m) !== (e[DW-1:0] & m))
            $display("FAIL wr_data: got %h required %h", buf_wr_data & m, e[DW-1:0] & m);
          else passed++;
        end
      end else if (hs) begin
        checks++;
        $display("FAIL missing_write: wr_en=0 after handshake of beat %0d", beat);
      end
      if (bad_beat >= 0 && hs && beat == bad_beat + 1) begin
        checks++;
        if (err_tlast !== 1'b1) $display("FAIL err_early_tlast: got %b required 1", err_tlast);
        else passed++;
      end
      if (done === 1'b1) begin
        done_seen = 1;
        checks++;
        if (!(hs && beat == total && buf_wr_en !== '0))
          $display("FAIL done_align: hs=%b beat=%0d wr_en=%h required last handshake %0d with write",
                   hs, beat, buf_wr_en, total);
        else passed++;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    checks++;
    if (!done_seen) $display("FAIL done_timeout: no done within %0d cycles", cyc);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL writes_left: %0d expected writes not seen, required 0", exp_q.size());
    else passed++;
    checks++;
    if (!tready_ok) $display("FAIL tready_load: tready low before all beats, required 1");
    else passed++;
    checks++;
    if (err_tlast !== (bad_beat >= 0)) $display("FAIL err_tlast: got %b required %b", err_tlast, bad_beat >= 0);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 1'b0)
      $display("FAIL after_fin: done=%b busy=%b tready=%b required 0 0 0", done, busy, s_axis_tready);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err_tlast, s_axis_tready, buf_wr_sel, buf_wr_en, buf_wr_addr} !== '0 || buf_wr_data !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b err=%b tready=%b sel=%b en=%h addr=%h required all 0",
               busy, done, err_tlast, s_axis_tready, buf_wr_sel, buf_wr_en, buf_wr_addr);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_axis_tready !== 1'b0) $display("FAIL idle_after_reset: busy=%b tready=%b required 0 0", busy, s_axis_tready);
    else passed++;
  endtask

  task automatic test_basic();
    run_xfer(32'h010, 2, 1'b1, 1'b0, -1);
  endtask

  task automatic test_stall();
    run_xfer(32'h010, 2, 1'b1, 1'b1, -1);
  endtask

  task automatic test_words0();
    int done_cnt, first_done;
    bit saw_tready, saw_en;
    done_cnt = 0; first_done = 0; saw_tready = 0; saw_en = 0;
    cfg_words = '0;
    cfg_base_addr = 9'h044;
    cfg_sel = 1'b0;
    cfg_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (s_axis_tready !== 1'b0) saw_tready = 1;
      if (buf_wr_en !== '0) saw_en = 1;
    end
    checks++;
    if (done_cnt != 1 || first_done < 1 || first_done > 2)
      $display("FAIL words0_done: pulses=%0d first=%0d required one pulse within 2 cycles", done_cnt, first_done);
    else passed++;
    checks++;
    if (saw_tready) $display("FAIL words0_tready: tready asserted, required never");
    else passed++;
    checks++;
    if (saw_en) $display("FAIL words0_wr_en: write enable seen, required none");
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL words0_idle: busy=%b required 0", busy);
    else passed++;
  endtask

  task automatic test_tlast_err();
    run_xfer(32'h080, 2, 1'b0, 1'b0, 2);
  endtask

  task automatic test_err_clear();
    run_xfer(32'h0A0, 1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_addr_wrap();
    run_xfer(32'h1FF, 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_midreset();
    int hs_cnt;
    hs_cnt = 0;
    cfg_words = 10'd2;
    cfg_base_addr = 9'h010;
    cfg_sel = 1'b1;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int c = 0; c < 20 && hs_cnt < 5; c++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom, $urandom};
      s_axis_tlast  = 1'b0;
      if (s_axis_tready) hs_cnt++;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err_tlast, s_axis_tready, buf_wr_sel, buf_wr_en, buf_wr_addr} !== '0 || buf_wr_data !== '0)
      $display("FAIL midreset_outputs: busy=%b done=%b tready=%b sel=%b en=%h addr=%h required all 0",
               busy, done, s_axis_tready, buf_wr_sel, buf_wr_en, buf_wr_addr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(32'h010, 2, 1'b1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++)
      run_xfer($urandom_range(0, 511), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), -1);
  endtask

  task automatic test_lane8();
    logic [63:0] d0, d1;
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    words8 = 10'd1;
    base8 = 9'h020;
    sel8 = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (tready8 !== 1'b1) $display("FAIL lane8_tready: got %b required 1", tready8);
    else passed++;
    tvalid8 = 1'b1; tdata8 = d0; tlast8 = 1'b0;
    @(negedge clk);
    checks++;
    if (en8 !== 14'h00FF || data8[63:0] !== d0 || addr8 !== 9'h020 || done8 !== 1'b0)
      $display("FAIL lane8_beat0: en=%h data=%h addr=%h done=%b required 00ff %h 020 0", en8, data8[63:0], addr8, done8, d0);
    else passed++;
    tdata8 = d1; tlast8 = 1'b1;
    @(negedge clk);
    tvalid8 = 1'b0; tlast8 = 1'b0;
    checks++;
    if (en8 !== 14'h3F00 || data8[111:64] !== d1[47:0] || addr8 !== 9'h020 || done8 !== 1'b1 || err8 !== 1'b0 || wsel8 !== 1'b1)
      $display("FAIL lane8_beat1: en=%h data=%h addr=%h done=%b err=%b sel=%b required 3f00 %h 020 1 0 1",
               en8, data8[111:64], addr8, done8, err8, wsel8, d1[47:0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (en8 !== '0 || done8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL lane8_end: en=%h done=%b busy=%b required 0 0 0", en8, done8, busy8);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_words0();
    test_tlast_err();
    test_err_clear();
    test_addr_wrap();
    test_midreset();
    test_random();
    test_lane8();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
